instr_prefetch_buffer: RTL and testbench

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/instr_prefetch_buffer_if.sv | 41 ++++
 rtl/instr_prefetch_buffer.sv | 128 ++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_buffer_if.sv
// rtl/instr_prefetch_buffer_if.sv - fetch/decode bundle for the instruction prefetch buffer
// Purpose : groups the instruction-memory handshake, redirect and decode-side signals.
// Signals : imem_req/imem_addr/imem_ack/imem_rdata (memory side),
//           redirect/redirect_pc (flush + restart),
//           inst_valid/inst_ready/inst_code/inst_pc/buf_count (decode side).
// Modports: master = prefetch buffer, slave = memory/decode environment.
interface instr_prefetch_buffer_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_code;
  logic [31:0]   inst_pc;
  logic [CW-1:0] buf_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_code, inst_pc, buf_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_code, inst_pc, buf_count
  );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - instruction prefetch FIFO with single-outstanding fetch FSM
// Purpose : fetches sequential instruction words into a DEPTH-entry {pc,code} FIFO,
//           handles redirects (flush + restart) including a request already in flight.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-low reset
//           bus       - instr_prefetch_buffer_if.master (memory, redirect, decode signals)
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_prefetch_buffer_if.master   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  // Address of the request being abandoned; the bus must keep showing it
  // while r_pc already holds the redirect target.
  logic [31:0]   r_drop_addr;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_code [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [CW-1:0] w_count_after;
  logic [31:0]   w_redir_pc;
  logic          w_unused_lsbs;

  assign w_redir_pc    = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_lsbs = ^bus.redirect_pc[1:0];

  assign w_valid       = (r_count != '0);
  // A redirect discards both the in-flight response and any pop that cycle.
  assign w_push        = (r_state == S_REQ) && bus.imem_ack && !bus.redirect;
  assign w_pop         = w_valid && bus.inst_ready && !bus.redirect;
  assign w_count_after = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (r_count < CW'(DEPTH)) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = bus.imem_ack ? S_REQ : S_DROP;
        end else if (bus.imem_ack) begin
          w_pc_nxt    = r_pc + 32'd4;
          // Stop issuing once this push fills the buffer so no push can hit a full FIFO.
          w_state_nxt = (w_count_after < CW'(DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.redirect) begin
          w_pc_nxt = w_redir_pc;
        end
        // The stale request retires on ack; the flushed buffer is empty, so reissue.
        if (bus.imem_ack) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if ((r_state == S_REQ) && bus.redirect && !bus.imem_ack) begin
        r_drop_addr <= r_pc;
      end
      if (bus.redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= w_count_after;
      end
    end
  end

  // Storage needs no reset: it is only observed through the count-gated head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc;
      r_mem_code[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req   = (r_state == S_REQ) || (r_state == S_DROP);
  assign bus.imem_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst_code  = w_valid ? r_mem_code[r_rd_ptr] : 32'd0;
  assign bus.inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : 32'd0;
  assign bus.buf_count  = r_count;
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - directed self-checking bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_prefetch_buffer_if #(.DEPTH(4)) bus ();

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: manual (driven by the main sequence) or auto (acks after mem_lat waits).
  logic        mem_auto  = 1'b0;
  int          mem_lat   = 0;
  logic        man_ack   = 1'b0;
  logic [31:0] man_rdata = 32'd0;
  logic        auto_ack  = 1'b0;
  logic [31:0] auto_rdata = 32'd0;
  int          wait_cnt  = 0;

  always @(negedge clk) begin
    if (!rst || !bus.imem_req) begin
      auto_ack <= 1'b0;
      wait_cnt <= 0;
    end else if (wait_cnt >= mem_lat) begin
      auto_ack   <= 1'b1;
      auto_rdata <= mdata(bus.imem_addr);
      wait_cnt   <= 0;
    end else begin
      auto_ack <= 1'b0;
      wait_cnt <= wait_cnt + 1;
    end
  end

  assign bus.imem_ack   = mem_auto ? auto_ack   : man_ack;
  assign bus.imem_rdata = mem_auto ? auto_rdata : man_rdata;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_code;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic [31:0] rd, input logic rdy,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ec, input logic [31:0] cnt);
    vec_t v;
    v.ack = ack; v.rdata = rd; v.ready = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_code = ec; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea, input logic ev,
                         input logic [31:0] ep, input logic [31:0] ec, input logic [31:0] cnt);
    chk({tag, ".req"},   32'(bus.imem_req),   32'(er));
    chk({tag, ".addr"},  bus.imem_addr,       ea);
    chk({tag, ".valid"}, 32'(bus.inst_valid), 32'(ev));
    chk({tag, ".pc"},    bus.inst_pc,         ep);
    chk({tag, ".code"},  bus.inst_code,       ec);
    chk({tag, ".count"}, 32'(bus.buf_count),  cnt);
  endtask

  vec_t vt[10];

  initial begin
    int c;
    int npop;
    logic seen_req;
    logic reached;

    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.inst_ready  = 1'b0;

    // Sequential fetch, ack one cycle after each request, decode always ready.
    vt[0] = mk(1'b0, 32'd0,         1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  32'd0,         32'd0);
    vt[1] = mk(1'b0, 32'd0,         1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0,         32'd0);
    vt[2] = mk(1'b1, 32'h1111_0000, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0,         32'd0);
    vt[3] = mk(1'b0, 32'd0,         1'b1, 1'b1, 32'd4,  1'b1, 32'd0,  32'h1111_0000, 32'd1);
    vt[4] = mk(1'b1, 32'h2222_0004, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0,  32'd0,         32'd0);
    vt[5] = mk(1'b0, 32'd0,         1'b1, 1'b1, 32'd8,  1'b1, 32'd4,  32'h2222_0004, 32'd1);
    vt[6] = mk(1'b1, 32'h3333_0008, 1'b1, 1'b1, 32'd8,  1'b0, 32'd0,  32'd0,         32'd0);
    vt[7] = mk(1'b0, 32'd0,         1'b1, 1'b1, 32'd12, 1'b1, 32'd8,  32'h3333_0008, 32'd1);
    vt[8] = mk(1'b1, 32'h4444_000C, 1'b1, 1'b1, 32'd12, 1'b0, 32'd0,  32'd0,         32'd0);
    vt[9] = mk(1'b0, 32'd0,         1'b1, 1'b1, 32'd16, 1'b1, 32'd12, 32'h4444_000C, 32'd1);

    @(negedge clk);
    chk_all("reset", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      chk_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid,
              vt[i].e_pc, vt[i].e_code, vt[i].e_cnt);
      man_ack        = vt[i].ack;
      man_rdata      = vt[i].rdata;
      bus.inst_ready = vt[i].ready;
      cyc();
    end

    // Redirect with ack in the same cycle: response dropped, low bits forced to 0.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    man_ack         = 1'b1;
    man_rdata       = 32'hBAD0_0001;
    cyc();
    bus.redirect = 1'b0;
    chk_all("redir_ack", 1'b1, 32'h0000_0100, 1'b0, 32'd0, 32'd0, 32'd0);
    man_ack   = 1'b1;
    man_rdata = 32'h0100_AAAA;
    cyc();
    chk_all("redir_fill", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0100_AAAA, 32'd1);

    // Redirect while request pending, ack 3 cycles late, second redirect while dropping.
    man_ack         = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    cyc();
    chk_all("drop0", 1'b1, 32'h0000_0104, 1'b0, 32'd0, 32'd0, 32'd0);
    bus.redirect_pc = 32'h0000_0302;
    cyc();
    bus.redirect = 1'b0;
    chk("drop1.addr", bus.imem_addr, 32'h0000_0104);
    cyc();
    chk("drop2.addr", bus.imem_addr, 32'h0000_0104);
    man_ack   = 1'b1;
    man_rdata = 32'hBAD0_0002;
    cyc();
    chk_all("drop_done", 1'b1, 32'h0000_0300, 1'b0, 32'd0, 32'd0, 32'd0);
    man_rdata = 32'h0300_5555;
    cyc();
    chk_all("drop_fill", 1'b1, 32'h0000_0304, 1'b1, 32'h0000_0300, 32'h0300_5555, 32'd1);

    // Fill to full, then pop and redirect together.
    man_ack        = 1'b0;
    bus.inst_ready = 1'b0;
    mem_lat        = 0;
    mem_auto       = 1'b1;
    c = 0;
    while (bus.buf_count != 3'd4 && c < 20) begin cyc(); c++; end
    cyc();
    cyc();
    chk_all("full", 1'b0, 32'h0000_0310, 1'b1, 32'h0000_0300, 32'h0300_5555, 32'd4);
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0400;
    cyc();
    bus.redirect = 1'b0;
    chk_all("full_redir", 1'b1, 32'h0000_0400, 1'b0, 32'd0, 32'd0, 32'd0);
    c = 0;
    while (!bus.inst_valid && c < 20) begin cyc(); c++; end
    chk("full_redir.pc",   bus.inst_pc,   32'h0000_0400);
    chk("full_redir.code", bus.inst_code, mdata(32'h0000_0400));

    // Reset pulse while a request is pending; ack during reset must be ignored.
    mem_auto = 1'b0;
    man_ack  = 1'b0;
    cyc();
    chk("pre_rst.req", 32'(bus.imem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    man_ack   = 1'b1;
    man_rdata = 32'hBAD0_0003;
    cyc();
    chk_all("rst_ack", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    man_ack        = 1'b0;
    bus.inst_ready = 1'b0;
    rst            = 1'b1;
    mem_auto       = 1'b1;
    cyc();
    chk("rst_rel.req",  32'(bus.imem_req), 32'd1);
    chk("rst_rel.addr", bus.imem_addr,     32'd0);

    // Zero-wait memory, decode stalled: exactly 4 buffered, then resume at 16.
    c = 0;
    while (bus.buf_count != 3'd4 && c < 20) begin cyc(); c++; end
    cyc();
    chk_all("stall_full", 1'b0, 32'd16, 1'b1, 32'd0, mdata(32'd0), 32'd4);
    bus.inst_ready = 1'b1;
    seen_req = 1'b0;
    npop     = 0;
    for (int k = 0; k < 40 && npop < 8; k++) begin
      if (!seen_req && bus.imem_req) begin
        seen_req = 1'b1;
        chk("resume.addr", bus.imem_addr, 32'd16);
      end
      if (bus.inst_valid) begin
        chk($sformatf("stream%0d.pc", npop),   bus.inst_pc,   32'(npop * 4));
        chk($sformatf("stream%0d.code", npop), bus.inst_code, mdata(32'(npop * 4)));
        npop++;
      end else if (npop > 0 && npop < 8) begin
        chk($sformatf("stream_gap%0d", npop), 32'(bus.inst_valid), 32'd1);
      end
      cyc();
    end
    chk("stream.pops", 32'(npop), 32'd8);
    reached = seen_req;
    chk("resume.seen", 32'(reached), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
